// File: rtl/issueq_int_pkg.sv
// Shared widths, integer opcode encodings and the issue-queue entry record.
// wake() is the CDB capture rule used for stored, shifted and newly written entries.
package issueq_int_pkg;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int OPC_W  = 4;
  localparam int IMM_W  = 16;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_BEQ = 4'd8,
    OP_BNE = 4'd9
  } int_op_e;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [IMM_W-1:0]  imm;
    logic [TAG_W-1:0]  rdtag;
    logic [TAG_W-1:0]  rstag;
    logic [TAG_W-1:0]  rttag;
    logic [DATA_W-1:0] rsdata;
    logic [DATA_W-1:0] rtdata;
    logic              rsvalid;
    logic              rtvalid;
  } entry_t;

  function automatic entry_t wake(input entry_t e, input logic cdb_vld,
                                  input logic [TAG_W-1:0] cdb_tag,
                                  input logic [DATA_W-1:0] cdb_dat);
    entry_t r;
    r = e;
    if (cdb_vld && !e.rsvalid && e.rstag == cdb_tag) begin
      r.rsvalid = 1'b1;
      r.rsdata  = cdb_dat;
    end
    if (cdb_vld && !e.rtvalid && e.rttag == cdb_tag) begin
      r.rtvalid = 1'b1;
      r.rtdata  = cdb_dat;
    end
    return r;
  endfunction
endpackage

// File: rtl/issueq_int_if.sv
// Dispatch, CDB and ALU-issue signals of the integer issue queue.
// master = surrounding pipeline, slave = the queue.
interface issueq_int_if;
  import issueq_int_pkg::*;

  logic              equeueint_en;
  logic              equeueint_ready;
  logic [OPC_W-1:0]  equeueint_opcode;
  logic [IMM_W-1:0]  equeue_imm;
  logic [TAG_W-1:0]  equeue_rdtag;
  logic [TAG_W-1:0]  equeue_rstag;
  logic [TAG_W-1:0]  equeue_rttag;
  logic [DATA_W-1:0] equeue_rsdata;
  logic [DATA_W-1:0] equeue_rtdata;
  logic              equeue_rsvalid;
  logic              equeue_rtvalid;
  logic [TAG_W-1:0]  cdb_tag;
  logic              cdb_valid;
  logic [DATA_W-1:0] cdb_data;
  logic              issueint_valid;
  logic              issueint_ready;
  logic [OPC_W-1:0]  issueint_opcode;
  logic [IMM_W-1:0]  issueint_imm;
  logic [TAG_W-1:0]  issueint_rdtag;
  logic [DATA_W-1:0] issueint_rsdata;
  logic [DATA_W-1:0] issueint_rtdata;

  modport master (
    output equeueint_en, equeueint_opcode, equeue_imm, equeue_rdtag, equeue_rstag,
           equeue_rttag, equeue_rsdata, equeue_rtdata, equeue_rsvalid, equeue_rtvalid,
           cdb_tag, cdb_valid, cdb_data, issueint_ready,
    input  equeueint_ready, issueint_valid, issueint_opcode, issueint_imm,
           issueint_rdtag, issueint_rsdata, issueint_rtdata
  );

  modport slave (
    input  equeueint_en, equeueint_opcode, equeue_imm, equeue_rdtag, equeue_rstag,
           equeue_rttag, equeue_rsdata, equeue_rtdata, equeue_rsvalid, equeue_rtvalid,
           cdb_tag, cdb_valid, cdb_data, issueint_ready,
    output equeueint_ready, issueint_valid, issueint_opcode, issueint_imm,
           issueint_rdtag, issueint_rsdata, issueint_rtdata
  );
endinterface

// File: rtl/issueq_int_entry.sv
// One issue-queue slot: holds, loads new, or takes its upper neighbour, snooping the CDB on each.
// Wakeup is visible on rdy one cycle after the CDB broadcast; no flow control of its own.
module issueq_int_entry
  import issueq_int_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              load,
  input  entry_t            load_dat,
  input  logic              shift,
  input  logic              shift_occ,
  input  entry_t            shift_dat,
  output logic              occ,
  output entry_t            dat,
  output logic              rdy
);
  entry_t nxt_self, nxt_shift, nxt_load;

  // An empty slot always holds zeros, so an empty neighbour shifts in a cleared payload.
  always_comb begin
    nxt_self  = wake(dat, cdb_valid & occ, cdb_tag, cdb_data);
    nxt_shift = shift_occ ? wake(shift_dat, cdb_valid, cdb_tag, cdb_data) : '0;
    nxt_load  = wake(load_dat, cdb_valid, cdb_tag, cdb_data);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= 1'b0;
      dat <= '0;
    end else if (load) begin
      occ <= 1'b1;
      dat <= nxt_load;
    end else if (shift) begin
      occ <= shift_occ;
      dat <= nxt_shift;
    end else begin
      dat <= nxt_self;
    end
  end

  assign rdy = occ & dat.rsvalid & dat.rtvalid;
endmodule

// File: rtl/issueq_int.sv
// Integer issue queue: age-ordered slots, CDB wakeup, oldest-ready select to the ALU (valid/ready).
// Enqueue-to-issue and wakeup-to-issue are one cycle; equeueint_ready depends on registered count only.
module issueq_int
  import issueq_int_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  issueq_int_if.slave q
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0] count, wr_idx;
  logic [DEPTH-1:0] occ, rdy;
  entry_t           dat [DEPTH];
  logic [IDX_W-1:0] sel;
  logic             any_rdy, issue_fire, en_fire;
  entry_t           new_dat, pick;

  always_comb begin
    new_dat         = '0;
    new_dat.opcode  = q.equeueint_opcode;
    new_dat.imm     = q.equeue_imm;
    new_dat.rdtag   = q.equeue_rdtag;
    new_dat.rstag   = q.equeue_rstag;
    new_dat.rttag   = q.equeue_rttag;
    new_dat.rsdata  = q.equeue_rsdata;
    new_dat.rtdata  = q.equeue_rtdata;
    new_dat.rsvalid = q.equeue_rsvalid;
    new_dat.rtvalid = q.equeue_rtvalid;
  end

  // Lowest ready index wins; slot 0 is the oldest.
  always_comb begin
    any_rdy = 1'b0;
    sel     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        any_rdy = 1'b1;
        sel     = IDX_W'(i);
      end
    end
  end

  assign issue_fire = q.issueint_valid & q.issueint_ready;
  assign en_fire    = q.equeueint_en & q.equeueint_ready;
  assign wr_idx     = count - CNT_W'(issue_fire);

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic   shift_occ;
    entry_t shift_dat;
    if (i == DEPTH - 1) begin : g_top
      assign shift_occ = 1'b0;
      assign shift_dat = '0;
    end else begin : g_mid
      assign shift_occ = occ[i+1];
      assign shift_dat = dat[i+1];
    end

    issueq_int_entry u_entry (
      .clk       (clk),
      .reset     (reset),
      .cdb_valid (q.cdb_valid),
      .cdb_tag   (q.cdb_tag),
      .cdb_data  (q.cdb_data),
      .load      (en_fire && wr_idx == CNT_W'(i)),
      .load_dat  (new_dat),
      .shift     (issue_fire && sel <= IDX_W'(i)),
      .shift_occ (shift_occ),
      .shift_dat (shift_dat),
      .occ       (occ[i]),
      .dat       (dat[i]),
      .rdy       (rdy[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(en_fire) - CNT_W'(issue_fire);
    end
  end

  always_comb begin
    pick              = (reset || !occ[0]) ? '0 : dat[sel];
    q.equeueint_ready = ~reset & (count < CNT_W'(DEPTH));
    q.issueint_valid  = ~reset & any_rdy;
    q.issueint_opcode = pick.opcode;
    q.issueint_imm    = pick.imm;
    q.issueint_rdtag  = pick.rdtag;
    q.issueint_rsdata = pick.rsdata;
    q.issueint_rtdata = pick.rtdata;
  end
endmodule

// File: tb/tb_issueq_int.sv
// Bench for issueq_int: age-ordered list model checked every cycle, plus directed literal checks.
module tb_issueq_int;
  import issueq_int_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  issueq_int_if q();
  issueq_int #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .q(q));

  typedef struct {
    logic [3:0]  opc;
    logic [15:0] imm;
    logic [5:0]  rd, rst, rtt;
    logic [31:0] rsd, rtd;
    bit          rsv, rtv;
  } op_t;

  op_t mq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t snoop(input op_t e, input logic cv, input logic [5:0] ct,
                                input logic [31:0] cd);
    op_t r;
    r = e;
    if (cv && !r.rsv && r.rst == ct) begin r.rsv = 1'b1; r.rsd = cd; end
    if (cv && !r.rtv && r.rtt == ct) begin r.rtv = 1'b1; r.rtd = cd; end
    return r;
  endfunction

  function automatic int first_ready();
    foreach (mq[i]) if (mq[i].rsv && mq[i].rtv) return i;
    return -1;
  endfunction

  // Model: compare at negedge, advance at posedge using the inputs held across that edge.
  initial begin : model
    int  fr;
    bit  iss, enf;
    op_t nw, e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_enq_ready", 64'(q.equeueint_ready), 64'd0);
        chk("rst_iss_valid", 64'(q.issueint_valid), 64'd0);
        chk("rst_rsdata", 64'(q.issueint_rsdata), 64'd0);
        chk("rst_rtdata", 64'(q.issueint_rtdata), 64'd0);
        chk("rst_rdtag", 64'(q.issueint_rdtag), 64'd0);
      end else begin
        fr = first_ready();
        chk("m_enq_ready", 64'(q.equeueint_ready), 64'(mq.size() < DEPTH));
        chk("m_iss_valid", 64'(q.issueint_valid), 64'(fr >= 0));
        chk("m_count", 64'(dut.count), 64'(mq.size()));
        if (mq.size() > 0) begin
          e = (fr >= 0) ? mq[fr] : mq[0];
          chk("m_opcode", 64'(q.issueint_opcode), 64'(e.opc));
          chk("m_imm", 64'(q.issueint_imm), 64'(e.imm));
          chk("m_rdtag", 64'(q.issueint_rdtag), 64'(e.rd));
          chk("m_rsdata", 64'(q.issueint_rsdata), 64'(e.rsd));
          chk("m_rtdata", 64'(q.issueint_rtdata), 64'(e.rtd));
        end
      end
      @(posedge clk);
      if (reset) begin
        mq.delete();
      end else begin
        fr  = first_ready();
        iss = (fr >= 0) && q.issueint_ready;
        enf = q.equeueint_en && (mq.size() < DEPTH);
        nw.opc = q.equeueint_opcode; nw.imm = q.equeue_imm; nw.rd = q.equeue_rdtag;
        nw.rst = q.equeue_rstag; nw.rtt = q.equeue_rttag;
        nw.rsd = q.equeue_rsdata; nw.rtd = q.equeue_rtdata;
        nw.rsv = q.equeue_rsvalid; nw.rtv = q.equeue_rtvalid;
        foreach (mq[i]) mq[i] = snoop(mq[i], q.cdb_valid, q.cdb_tag, q.cdb_data);
        if (iss) mq.delete(fr);
        if (enf) mq.push_back(snoop(nw, q.cdb_valid, q.cdb_tag, q.cdb_data));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] opc, input logic [15:0] imm, input logic [5:0] rd,
                        input logic [5:0] rst, input logic [5:0] rtt, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic rsv, input logic rtv);
    q.equeueint_en = 1'b1; q.equeueint_opcode = opc; q.equeue_imm = imm;
    q.equeue_rdtag = rd; q.equeue_rstag = rst; q.equeue_rttag = rtt;
    q.equeue_rsdata = rsd; q.equeue_rtdata = rtd;
    q.equeue_rsvalid = rsv; q.equeue_rtvalid = rtv;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    q.cdb_valid = 1'b1; q.cdb_tag = tag; q.cdb_data = data;
  endtask

  task automatic idle();
    q.equeueint_en = 1'b0;
    q.cdb_valid    = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stim
    reset = 1'b1;
    set_op(4'd0, 16'd0, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle();
    q.cdb_tag = '0; q.cdb_data = '0;
    q.issueint_ready = 1'b1;
    repeat (2) cyc();
    chk("L_rst_ready", 64'(q.equeueint_ready), 64'd0);
    chk("L_rst_valid", 64'(q.issueint_valid), 64'd0);
    reset = 1'b0;
    cyc();
    chk("L_ready_after_rst", 64'(q.equeueint_ready), 64'd1);

    // 1: fully ready op issues the cycle after enqueue
    set_op(OP_ADD, 16'h0011, 6'd3, 6'd0, 6'd0, 32'd5, 32'd7, 1'b1, 1'b1);
    cyc(); idle();
    chk("T1_valid", 64'(q.issueint_valid), 64'd1);
    chk("T1_rs", 64'(q.issueint_rsdata), 64'd5);
    chk("T1_rt", 64'(q.issueint_rtdata), 64'd7);
    chk("T1_rd", 64'(q.issueint_rdtag), 64'd3);
    cyc();
    chk("T1_valid_after", 64'(q.issueint_valid), 64'd0);
    chk("T1_count", 64'(dut.count), 64'd0);

    // 2: CDB wakeup, valid exactly one cycle after the broadcast
    set_op(OP_SUB, 16'h0022, 6'd4, 6'd9, 6'd0, 32'd0, 32'd2, 1'b0, 1'b1);
    cyc(); idle();
    chk("T2_wait", 64'(q.issueint_valid), 64'd0);
    cyc(); cyc();
    cdb(6'd9, 32'h55);
    chk("T2_pre_cdb", 64'(q.issueint_valid), 64'd0);
    cyc(); idle();
    chk("T2_valid", 64'(q.issueint_valid), 64'd1);
    chk("T2_rs", 64'(q.issueint_rsdata), 64'h55);
    cyc();
    chk("T2_drained", 64'(q.issueint_valid), 64'd0);

    // 3: fill, enqueue while full ignored, wake middle entry
    for (int k = 0; k < 4; k++) begin
      set_op(OP_AND, 16'(k), 6'(k), 6'(20 + k), 6'd0, 32'd0, 32'(k), 1'b0, 1'b1);
      cyc();
    end
    chk("T3_full_ready", 64'(q.equeueint_ready), 64'd0);
    chk("T3_full_count", 64'(dut.count), 64'd4);
    set_op(OP_OR, 16'hFFFF, 6'd60, 6'd0, 6'd0, 32'd1, 32'd1, 1'b1, 1'b1);
    cyc(); idle();
    chk("T3_ignored_count", 64'(dut.count), 64'd4);
    chk("T3_ignored_valid", 64'(q.issueint_valid), 64'd0);
    cdb(6'd22, 32'h22);
    cyc(); idle();
    chk("T3_valid", 64'(q.issueint_valid), 64'd1);
    chk("T3_rd", 64'(q.issueint_rdtag), 64'd2);
    chk("T3_rs", 64'(q.issueint_rsdata), 64'h22);
    cyc();
    chk("T3_ready_back", 64'(q.equeueint_ready), 64'd1);
    chk("T3_count3", 64'(dut.count), 64'd3);
    cdb(6'd20, 32'h20); cyc();
    cdb(6'd21, 32'h21); cyc();
    cdb(6'd23, 32'h23); cyc();
    idle(); cyc(); cyc();
    chk("T3_empty", 64'(dut.count), 64'd0);

    // 4: one tag wakes several entries; oldest first, rs and rt on the same tag
    q.issueint_ready = 1'b0;
    set_op(OP_OR,  16'd0, 6'd10, 6'd12, 6'd0,  32'd0, 32'd1, 1'b0, 1'b1); cyc();
    set_op(OP_XOR, 16'd0, 6'd11, 6'd0,  6'd12, 32'd3, 32'd0, 1'b1, 1'b0); cyc();
    set_op(OP_SLT, 16'd0, 6'd13, 6'd12, 6'd12, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    idle();
    cdb(6'd12, 32'hC);
    cyc(); idle();
    chk("T4_first_rd", 64'(q.issueint_rdtag), 64'd10);
    chk("T4_first_rs", 64'(q.issueint_rsdata), 64'hC);
    q.issueint_ready = 1'b1;
    cyc();
    chk("T4_second_rd", 64'(q.issueint_rdtag), 64'd11);
    chk("T4_second_rt", 64'(q.issueint_rtdata), 64'hC);
    cyc();
    chk("T4_third_rd", 64'(q.issueint_rdtag), 64'd13);
    chk("T4_third_rs", 64'(q.issueint_rsdata), 64'hC);
    chk("T4_third_rt", 64'(q.issueint_rtdata), 64'hC);
    cyc();
    chk("T4_done", 64'(q.issueint_valid), 64'd0);

    // 5: enqueue snoops the same-cycle CDB
    set_op(OP_SLL, 16'd0, 6'd5, 6'd4, 6'd0, 32'd0, 32'd9, 1'b0, 1'b1);
    cdb(6'd4, 32'hA);
    cyc(); idle();
    chk("T5_valid", 64'(q.issueint_valid), 64'd1);
    chk("T5_rs", 64'(q.issueint_rsdata), 64'hA);
    cyc();
    chk("T5_count", 64'(dut.count), 64'd0);

    // enqueue + issue + CDB together
    q.issueint_ready = 1'b0;
    set_op(OP_SRL, 16'd0, 6'd30, 6'd0, 6'd0, 32'd1, 32'd1, 1'b1, 1'b1); cyc();
    set_op(OP_BEQ, 16'd0, 6'd31, 6'd40, 6'd0, 32'd0, 32'd2, 1'b0, 1'b1); cyc();
    idle();
    chk("TS_pre_rd", 64'(q.issueint_rdtag), 64'd30);
    q.issueint_ready = 1'b1;
    set_op(OP_BNE, 16'd0, 6'd32, 6'd0, 6'd0, 32'd6, 32'd6, 1'b1, 1'b1);
    cdb(6'd40, 32'h40);
    cyc(); idle();
    chk("TS_count", 64'(dut.count), 64'd2);
    chk("TS_rd", 64'(q.issueint_rdtag), 64'd31);
    chk("TS_rs", 64'(q.issueint_rsdata), 64'h40);
    cyc();
    chk("TS_next_rd", 64'(q.issueint_rdtag), 64'd32);
    cyc();

    // 6: stall holds payload, then reset mid-run
    q.issueint_ready = 1'b0;
    set_op(OP_ADD, 16'hBEEF, 6'd50, 6'd0, 6'd0, 32'h50, 32'h51, 1'b1, 1'b1);
    cyc(); idle();
    for (int k = 0; k < 5; k++) begin
      chk("T6_stall_valid", 64'(q.issueint_valid), 64'd1);
      chk("T6_stall_rd", 64'(q.issueint_rdtag), 64'd50);
      chk("T6_stall_rs", 64'(q.issueint_rsdata), 64'h50);
      cyc();
    end
    reset = 1'b1;
    cyc();
    chk("T6_rst_valid", 64'(q.issueint_valid), 64'd0);
    chk("T6_rst_ready", 64'(q.equeueint_ready), 64'd0);
    reset = 1'b0;
    cyc();
    chk("T6_ready", 64'(q.equeueint_ready), 64'd1);
    chk("T6_valid", 64'(q.issueint_valid), 64'd0);
    chk("T6_count", 64'(dut.count), 64'd0);
    q.issueint_ready = 1'b1;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
